// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: PC sequencer and registered instruction hand-off to decode with redirect, halt, stall and fault handling
module instr_fetch_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int MEM_BYTES = 128,
  parameter int RESET_PC  = 0,
  parameter int WRAP      = 0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] PCAddress,
  input  logic [15:0]       Instruction,
  output logic [15:0]       InstrOut,
  output logic [ADDR_W-1:0] InstrPC,
  output logic              InstrValid,
  input  logic              InstrReady,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectTarget,
  input  logic              Halt,
  output logic              Halted,
  output logic              Fault,
  output logic [15:0]       FetchCount
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;
  localparam logic [1:0] S_FAULT  = 2'd3;
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(MEM_BYTES - 2);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  logic [1:0]        state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, instr_pc_n;
  logic [15:0]       instr_out_n;
  logic              valid_n, target_ok, transfer;
  assign PCAddress = pc;
  assign Halted    = state == S_HALTED;
  assign Fault     = state == S_FAULT;
  assign transfer  = InstrValid & InstrReady;
  assign target_ok = ~RedirectTarget[0] & (RedirectTarget <= LAST_PC);
  // next-state: a transfer frees the output slot unless this cycle refills or flushes it
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    instr_out_n = InstrOut;
    instr_pc_n  = InstrPC;
    valid_n     = InstrValid & ~InstrReady;
    case (state)
      S_IDLE: state_n = Start ? S_RUN : S_IDLE;
      S_RUN:
        if (Halt) begin
          valid_n = 1'b0;
          state_n = S_HALTED;
        end else if (Redirect) begin
          valid_n = 1'b0;
          pc_n    = target_ok ? RedirectTarget : pc;
          state_n = target_ok ? S_RUN : S_FAULT;
        end else if (!InstrValid || InstrReady) begin
          instr_out_n = Instruction;
          instr_pc_n  = pc;
          valid_n     = 1'b1;
          if (pc == LAST_PC) begin
            pc_n    = (WRAP != 0) ? '0 : pc;
            state_n = (WRAP != 0) ? S_RUN : S_FAULT;
          end else begin
            pc_n = pc + ADDR_W'(2);
          end
        end
      S_HALTED:
        if (Redirect) begin
          pc_n    = target_ok ? RedirectTarget : pc;
          state_n = !target_ok ? S_FAULT : Start ? S_RUN : S_HALTED;
        end else begin
          state_n = Start ? S_RUN : S_HALTED;
        end
      default: ;
    endcase
  end
  // state, PC, output slot and transfer counter registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      pc         <= RST_PC;
      InstrOut   <= '0;
      InstrPC    <= '0;
      InstrValid <= 1'b0;
      FetchCount <= '0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      InstrOut   <= instr_out_n;
      InstrPC    <= instr_pc_n;
      InstrValid <= valid_n;
      FetchCount <= FetchCount + {15'd0, transfer};
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed and randomized checks of instr_fetch_ctrl against a behavioural model
module tb_instr_fetch_ctrl;
  localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2, S_FAULT = 3;
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;
  logic        Reset, Start, InstrReady, Redirect, Halt;
  logic [15:0] RedirectTarget, Instruction, PCAddress, InstrOut, InstrPC, FetchCount;
  logic        InstrValid, Halted, Fault;
  logic        w_rst, w_start, w_ready, w_valid, w_halted, w_fault;
  logic [15:0] w_instr, w_pca, w_out, w_ipc, w_cnt;
  logic [7:0]  mem [0:127];
  int errors = 0, checks = 0;
  int          m_st;
  logic [15:0] m_pc, m_out, m_ipc, m_cnt;
  logic        m_v;

  instr_fetch_ctrl #(.ADDR_W(16), .MEM_BYTES(128), .RESET_PC(0), .WRAP(0)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .PCAddress(PCAddress), .Instruction(Instruction),
    .InstrOut(InstrOut), .InstrPC(InstrPC), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget), .Halt(Halt), .Halted(Halted),
    .Fault(Fault), .FetchCount(FetchCount));

  instr_fetch_ctrl #(.ADDR_W(16), .MEM_BYTES(128), .RESET_PC(0), .WRAP(1)) dut_w (
    .Clock(Clock), .Reset(w_rst), .Start(w_start), .PCAddress(w_pca), .Instruction(w_instr),
    .InstrOut(w_out), .InstrPC(w_ipc), .InstrValid(w_valid), .InstrReady(w_ready),
    .Redirect(1'b0), .RedirectTarget(16'h0000), .Halt(1'b0), .Halted(w_halted),
    .Fault(w_fault), .FetchCount(w_cnt));

  function automatic logic [15:0] word_at(logic [15:0] a);
    return {mem[a[6:0]], mem[a[6:0] + 7'd1]};
  endfunction

  assign Instruction = word_at(PCAddress);
  assign w_instr     = word_at(w_pca);

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_pc = 0; m_out = 0; m_ipc = 0; m_v = 0; m_cnt = 0;
  endtask

  // one clock of the fetch rules, evaluated on the values present before the edge
  task automatic model_step();
    logic legal;
    legal = !RedirectTarget[0] && RedirectTarget <= 16'd126;
    if (m_v && InstrReady) begin
      m_cnt = m_cnt + 1;
      m_v = 0;
      if (m_st == S_RUN && !Halt && !Redirect) m_v = 1;
    end
    if (m_st == S_IDLE) begin
      if (Start) m_st = S_RUN;
    end else if (m_st == S_RUN) begin
      if (Halt) begin
        m_v = 0; m_st = S_HALT;
      end else if (Redirect) begin
        m_v = 0;
        if (legal) m_pc = RedirectTarget; else m_st = S_FAULT;
      end else if (!m_v || InstrReady) begin
        m_out = word_at(m_pc); m_ipc = m_pc; m_v = 1;
        if (m_pc == 16'd126) m_st = S_FAULT; else m_pc = m_pc + 2;
      end
    end else if (m_st == S_HALT) begin
      if (Redirect) begin
        if (!legal) m_st = S_FAULT;
        else begin
          m_pc = RedirectTarget;
          if (Start) m_st = S_RUN;
        end
      end else if (Start) m_st = S_RUN;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".pc"}, 32'(PCAddress), 32'(m_pc));
    chk({tag, ".out"}, 32'(InstrOut), 32'(m_out));
    chk({tag, ".ipc"}, 32'(InstrPC), 32'(m_ipc));
    chk({tag, ".valid"}, 32'(InstrValid), 32'(m_v));
    chk({tag, ".halted"}, 32'(Halted), 32'(m_st == S_HALT));
    chk({tag, ".fault"}, 32'(Fault), 32'(m_st == S_FAULT));
    chk({tag, ".count"}, 32'(FetchCount), 32'(m_cnt));
  endtask

  task automatic cyc(string tag);
    model_step();
    @(posedge Clock);
    #1;
    check_all(tag);
  endtask

  task automatic clear_in();
    Start = 0; InstrReady = 0; Redirect = 0; Halt = 0; RedirectTarget = 0;
  endtask

  task automatic run_reset();
    clear_in();
    Reset = 1;
    @(posedge Clock);
    #1;
    model_reset();
    check_all("rst");
    Reset = 0;
  endtask

  // called at edge+1: asserts reset between edges and checks outputs before the next edge
  task automatic async_reset();
    #2;
    Reset = 1;
    #1;
    chk("areset.valid", 32'(InstrValid), 32'd0);
    chk("areset.pc", 32'(PCAddress), 32'd0);
    chk("areset.count", 32'(FetchCount), 32'd0);
    model_reset();
    check_all("areset");
    #1;
    Reset = 0;
    clear_in();
  endtask

  initial begin
    int wexp [4];
    logic [15:0] cnt0;
    wexp = '{124, 126, 0, 2};
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
    w_rst = 1; w_start = 0; w_ready = 0;
    clear_in();
    Reset = 1;
    model_reset();
    @(posedge Clock);
    #1;
    chk("reset.valid", 32'(InstrValid), 32'd0);
    chk("reset.count", 32'(FetchCount), 32'd0);
    check_all("reset");
    Reset = 0;
    // sequential fetch at full throughput
    Start = 1; InstrReady = 1;
    cyc("t1.start");
    Start = 0;
    cyc("t1.w0");
    chk("t1.w0", 32'(InstrOut), 32'h1122);
    chk("t1.p0", 32'(InstrPC), 32'd0);
    cyc("t1.w1");
    chk("t1.w1", 32'(InstrOut), 32'h3344);
    chk("t1.p1", 32'(InstrPC), 32'd2);
    cyc("t1.w2");
    chk("t1.w2", 32'(InstrOut), 32'h5566);
    chk("t1.p2", 32'(InstrPC), 32'd4);
    // stall with 0x3344 held
    run_reset();
    Start = 1; InstrReady = 1;
    cyc("t2.start");
    Start = 0;
    cyc("t2.a");
    cyc("t2.b");
    InstrReady = 0;
    cnt0 = FetchCount;
    for (int i = 0; i < 3; i++) begin
      cyc("t2.stall");
      chk("t2.stall_out", 32'(InstrOut), 32'h3344);
      chk("t2.stall_ipc", 32'(InstrPC), 32'd2);
      chk("t2.stall_pca", 32'(PCAddress), 32'd4);
    end
    InstrReady = 1;
    cyc("t2.release");
    chk("t2.count", 32'(FetchCount), 32'(cnt0 + 16'd1));
    chk("t2.next", 32'(InstrOut), 32'h5566);
    // legal redirect, then illegal odd target
    run_reset();
    Start = 1;
    cyc("t3.start");
    Start = 0; InstrReady = 1;
    cyc("t3.w0");
    InstrReady = 0; Redirect = 1; RedirectTarget = 16'h0010;
    cyc("t3.redir");
    chk("t3.flush", 32'(InstrValid), 32'd0);
    Redirect = 0; InstrReady = 1;
    cyc("t3.new");
    chk("t3.newpc", 32'(InstrPC), 32'h0010);
    Redirect = 1; RedirectTarget = 16'h0011;
    cyc("t3.odd");
    chk("t3.odd_fault", 32'(Fault), 32'd1);
    Redirect = 0; Start = 1;
    cyc("t3.ign0");
    cyc("t3.ign1");
    chk("t3.stuck", 32'(Fault), 32'd1);
    chk("t3.novalid", 32'(InstrValid), 32'd0);
    // out-of-range target
    run_reset();
    Start = 1;
    cyc("t3b.start");
    Start = 0; InstrReady = 1;
    cyc("t3b.w0");
    Redirect = 1; RedirectTarget = 16'h0080;
    cyc("t3b.range");
    chk("t3b.fault", 32'(Fault), 32'd1);
    Redirect = 0;
    // halt, resume, halt with redirect
    run_reset();
    Start = 1; InstrReady = 1;
    cyc("t4.start");
    Start = 0;
    for (int i = 0; i < 3; i++) cyc("t4.run");
    Halt = 1;
    cyc("t4.halt");
    chk("t4.halted", 32'(Halted), 32'd1);
    chk("t4.pca", 32'(PCAddress), 32'd6);
    Halt = 0;
    cyc("t4.hold");
    chk("t4.pca_hold", 32'(PCAddress), 32'd6);
    Start = 1;
    cyc("t4.resume");
    Start = 0;
    cyc("t4.fetch6");
    chk("t4.ipc6", 32'(InstrPC), 32'd6);
    Halt = 1; Redirect = 1; RedirectTarget = 16'h0020;
    cyc("t4.hr");
    chk("t4.hr_halted", 32'(Halted), 32'd1);
    chk("t4.hr_pca", 32'(PCAddress), 32'd8);
    Halt = 0; Redirect = 0;
    // run off the end without wrap
    run_reset();
    Start = 1; InstrReady = 1;
    cyc("t5.start");
    Start = 0;
    for (int i = 0; i < 64; i++) cyc("t5.run");
    chk("t5.ipc", 32'(InstrPC), 32'd126);
    chk("t5.valid", 32'(InstrValid), 32'd1);
    chk("t5.fault", 32'(Fault), 32'd1);
    cyc("t5.drain");
    chk("t5.drained", 32'(InstrValid), 32'd0);
    chk("t5.count", 32'(FetchCount), 32'd64);
    // wrap instance
    Reset = 1;
    w_rst = 0; w_start = 1; w_ready = 1;
    @(posedge Clock);
    #1;
    w_start = 0;
    repeat (62) @(posedge Clock);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock);
      #1;
      chk("t5w.ipc", 32'(w_ipc), 32'(wexp[i]));
      chk("t5w.valid", 32'(w_valid), 32'd1);
      chk("t5w.fault", 32'(w_fault), 32'd0);
    end
    w_rst = 1;
    // asynchronous reset mid-stream
    run_reset();
    Start = 1; InstrReady = 1;
    cyc("t6.start");
    Start = 0;
    cyc("t6.a");
    cyc("t6.b");
    async_reset();
    // randomized traffic
    run_reset();
    for (int i = 0; i < 800; i++) begin
      Start = $urandom_range(0, 3) == 0;
      InstrReady = $urandom_range(0, 3) != 0;
      Redirect = $urandom_range(0, 7) == 0;
      RedirectTarget = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63) * 2);
      Halt = $urandom_range(0, 15) == 0;
      cyc("rnd");
      if ($urandom_range(0, 63) == 0 || (m_st == S_FAULT && $urandom_range(0, 7) == 0)) async_reset();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
